// File: rtl/cache_pkg.sv
// ============================================================================
// Module   : cache_pkg
// Brief    : Shared constants, types and helpers for the tag lookup slice.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  localparam int C_WAYS     = 4;
  localparam int C_SET_BITS = 6;
  localparam int C_TAG_BITS = 20;

  typedef logic [2:0]        plru_t;
  typedef logic [C_WAYS-1:0] way_vec_t;

  // Isolates the lowest set bit (two's-complement trick); zero in, zero out.
  function automatic way_vec_t onehot_lowest(input way_vec_t v);
    return v & (~v + way_vec_t'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/plru_tree4.sv
// ============================================================================
// Module   : plru_tree4
// Brief    : 4-way tree pseudo-LRU: victim from state bits, next state on access.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module plru_tree4
  import cache_pkg::*;
(
  input  plru_t    i_bits,
  input  way_vec_t i_access,
  output way_vec_t o_victim,
  output plru_t    o_next
);

  // Bit 0 picks the half, bit 1 the way in the low half, bit 2 the way in the high half.
  always_comb begin
    o_victim = '0;
    case ({i_bits[0], i_bits[1], i_bits[2]})
      3'b000, 3'b001: o_victim = 4'b0001;
      3'b010, 3'b011: o_victim = 4'b0010;
      3'b100, 3'b110: o_victim = 4'b0100;
      default:        o_victim = 4'b1000;
    endcase
  end

  always_comb begin
    o_next = i_bits;
    if (i_access[0] || i_access[1]) begin
      o_next[0] = 1'b1;
      o_next[1] = i_access[0];
    end else if (i_access[2] || i_access[3]) begin
      o_next[0] = 1'b0;
      o_next[2] = i_access[2];
    end
  end

endmodule

`default_nettype wire

// File: rtl/tag_lookup.sv
// ============================================================================
// Module   : tag_lookup
// Brief    : Two-stage tag compare with per-set valid bits, PLRU and victim select.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tag_lookup
  import cache_pkg::*;
#(
  parameter int WAYS     = C_WAYS,
  parameter int SETS     = 64,
  parameter int TAG_BITS = C_TAG_BITS
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [$clog2(SETS)-1:0] i_req_set,
  input  logic [TAG_BITS-1:0]     i_req_tag,
  output logic                    o_tag_rd_en,
  output logic [$clog2(SETS)-1:0] o_tag_rd_set,
  input  logic [TAG_BITS-1:0]     i_tag_rd_data [WAYS-1:0],
  output logic                    o_rsp_valid,
  input  logic                    i_rsp_ready,
  output logic [WAYS-1:0]         o_sel,
  output logic                    o_hit,
  output logic                    o_multi_hit,
  output logic [WAYS-1:0]         o_victim,
  input  logic                    i_fill_valid,
  input  logic [$clog2(SETS)-1:0] i_fill_set,
  input  logic [WAYS-1:0]         i_fill_way,
  input  logic                    i_inv_valid,
  input  logic [$clog2(SETS)-1:0] i_inv_set,
  input  logic [WAYS-1:0]         i_inv_way
);

  localparam int SET_BITS = $clog2(SETS);

  logic [WAYS-1:0]     r_valid [SETS];
  logic [WAYS-1:0]     w_valid_nxt [SETS];
  plru_t               r_plru [SETS];

  logic                r_s1_valid;
  logic [SET_BITS-1:0] r_s1_set;
  logic [TAG_BITS-1:0] r_s1_tag;

  logic                r_s2_valid;
  logic [SET_BITS-1:0] r_s2_set;
  logic [WAYS-1:0]     r_sel;
  logic                r_hit;
  logic                r_multi_hit;
  logic [WAYS-1:0]     r_victim;

  logic                w_req_ready;
  logic                w_accept;
  logic [WAYS-1:0]     w_row;
  logic [WAYS-1:0]     w_match;
  logic [WAYS-1:0]     w_sel;
  logic                w_multi;
  logic [WAYS-1:0]     w_victim;
  logic [WAYS-1:0]     w_plru_victim;
  logic                w_hit_upd;
  plru_t               w_hit_next;
  plru_t               w_fill_next;
  plru_t               w_rd_next_unused;
  logic [WAYS-1:0]     w_hit_victim_unused;
  logic [WAYS-1:0]     w_fill_victim_unused;

  // S1 always drains into S2 next cycle, so S2 must be free or draining now.
  assign w_req_ready  = !r_s1_valid && (!r_s2_valid || i_rsp_ready);
  assign w_accept     = i_req_valid && w_req_ready;
  assign o_req_ready  = w_req_ready;
  assign o_tag_rd_en  = w_accept;
  assign o_tag_rd_set = i_req_set;

  // ---------------------------------------------------------------- compare
  assign w_row = r_valid[r_s1_set];

  for (genvar w = 0; w < WAYS; w++) begin : g_match
    assign w_match[w] = w_row[w] && (i_tag_rd_data[w] == r_s1_tag);
  end

  assign w_sel    = onehot_lowest(w_match);
  assign w_multi  = |(w_match & (w_match - WAYS'(1)));
  assign w_victim = (&w_row) ? w_plru_victim : onehot_lowest(~w_row);

  plru_tree4 u_plru_rd (
    .i_bits   (r_plru[r_s1_set]),
    .i_access ('0),
    .o_victim (w_plru_victim),
    .o_next   (w_rd_next_unused)
  );

  // ---------------------------------------------------------------- PLRU update paths
  assign w_hit_upd = r_s2_valid && i_rsp_ready && r_hit;

  plru_tree4 u_plru_hit (
    .i_bits   (r_plru[r_s2_set]),
    .i_access (r_sel),
    .o_victim (w_hit_victim_unused),
    .o_next   (w_hit_next)
  );

  plru_tree4 u_plru_fill (
    .i_bits   (r_plru[i_fill_set]),
    .i_access (i_fill_way),
    .o_victim (w_fill_victim_unused),
    .o_next   (w_fill_next)
  );

  // ---------------------------------------------------------------- pipeline
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_set   <= '0;
      r_s1_tag   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_set <= i_req_set;
        r_s1_tag <= i_req_tag;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_valid  <= 1'b0;
      r_s2_set    <= '0;
      r_sel       <= '0;
      r_hit       <= 1'b0;
      r_multi_hit <= 1'b0;
      r_victim    <= WAYS'(1);
    end else if (r_s1_valid) begin
      r_s2_valid  <= 1'b1;
      r_s2_set    <= r_s1_set;
      r_sel       <= w_sel;
      r_hit       <= |w_match;
      r_multi_hit <= w_multi;
      r_victim    <= w_victim;
    end else if (i_rsp_ready) begin
      r_s2_valid  <= 1'b0;
    end
  end

  assign o_rsp_valid = r_s2_valid;
  assign o_sel       = r_sel;
  assign o_hit       = r_hit;
  assign o_multi_hit = r_multi_hit;
  assign o_victim    = r_victim;

  // ---------------------------------------------------------------- valid bits
  // Invalidate is applied after fill so it wins on a same-set/way collision.
  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      w_valid_nxt[s] = r_valid[s];
      if (i_fill_valid && (i_fill_set == SET_BITS'(s)))
        w_valid_nxt[s] = w_valid_nxt[s] | i_fill_way;
      if (i_inv_valid && (i_inv_set == SET_BITS'(s)))
        w_valid_nxt[s] = w_valid_nxt[s] & ~i_inv_way;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= '0;
    end else begin
      for (int s = 0; s < SETS; s++) r_valid[s] <= w_valid_nxt[s];
    end
  end

  // Fill is written last so it overrides a hit update to the same set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) r_plru[s] <= '0;
    end else begin
      if (w_hit_upd)    r_plru[r_s2_set]   <= w_hit_next;
      if (i_fill_valid) r_plru[i_fill_set] <= w_fill_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_tag_lookup.sv
// ============================================================================
// Module   : tb_tag_lookup
// Brief    : Directed self-checking bench for tag_lookup.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tag_lookup;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  req_set;
  logic [19:0] req_tag;
  logic        tag_rd_en;
  logic [5:0]  tag_rd_set;
  logic [19:0] tag_data [3:0];
  logic        rsp_valid;
  logic        rsp_ready;
  logic [3:0]  sel;
  logic        hit;
  logic        multi_hit;
  logic [3:0]  victim;
  logic        fill_valid;
  logic [5:0]  fill_set;
  logic [3:0]  fill_way;
  logic        inv_valid;
  logic [5:0]  inv_set;
  logic [3:0]  inv_way;

  int n_vec = 0;
  int n_bad = 0;

  tag_lookup #(.WAYS(4), .SETS(64), .TAG_BITS(20)) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_req_valid   (req_valid),
    .o_req_ready   (req_ready),
    .i_req_set     (req_set),
    .i_req_tag     (req_tag),
    .o_tag_rd_en   (tag_rd_en),
    .o_tag_rd_set  (tag_rd_set),
    .i_tag_rd_data (tag_data),
    .o_rsp_valid   (rsp_valid),
    .i_rsp_ready   (rsp_ready),
    .o_sel         (sel),
    .o_hit         (hit),
    .o_multi_hit   (multi_hit),
    .o_victim      (victim),
    .i_fill_valid  (fill_valid),
    .i_fill_set    (fill_set),
    .i_fill_way    (fill_way),
    .i_inv_valid   (inv_valid),
    .i_inv_set     (inv_set),
    .i_inv_way     (inv_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_tags(input logic [19:0] t0, input logic [19:0] t1,
                          input logic [19:0] t2, input logic [19:0] t3);
    tag_data[0] = t0;
    tag_data[1] = t1;
    tag_data[2] = t2;
    tag_data[3] = t3;
  endtask

  task automatic do_fill(input logic [5:0] s, input logic [3:0] w);
    @(negedge clk);
    fill_valid = 1'b1;
    fill_set   = s;
    fill_way   = w;
    @(negedge clk);
    fill_valid = 1'b0;
  endtask

  // Issue one lookup with rsp_ready high; checks accept, S1 and S2 cycles.
  task automatic do_lookup(input string name, input logic [5:0] s, input logic [19:0] t,
                           input logic exp_hit, input logic [3:0] exp_sel,
                           input logic exp_multi, input logic [3:0] exp_vic);
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = s;
    req_tag   = t;
    #1;
    check({name, ".rd_en"},  tag_rd_en, 1);
    check({name, ".rd_set"}, tag_rd_set, s);
    @(negedge clk);
    req_valid = 1'b0;
    check({name, ".s1_norsp"}, rsp_valid, 0);
    @(negedge clk);
    check({name, ".rsp_valid"}, rsp_valid, 1);
    check({name, ".hit"},       hit, exp_hit);
    check({name, ".sel"},       sel, exp_sel);
    check({name, ".multi"},     multi_hit, exp_multi);
    if (!exp_hit) check({name, ".victim"}, victim, exp_vic);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_set    = '0;
    req_tag    = '0;
    rsp_ready  = 1'b1;
    fill_valid = 1'b0;
    fill_set   = '0;
    fill_way   = '0;
    inv_valid  = 1'b0;
    inv_set    = '0;
    inv_way    = '0;
    set_tags(20'h0, 20'h0, 20'h0, 20'h0);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.rsp_valid", rsp_valid, 0);
    check("rst.sel",       sel, 0);
    check("rst.hit",       hit, 0);
    check("rst.multi",     multi_hit, 0);
    check("rst.victim",    victim, 4'b0001);
    rst = 1'b0;
    #1;
    check("rst.req_ready", req_ready, 1);

    // Cold miss then fill-and-hit on set 5
    set_tags(20'h00ABC, 20'h0, 20'h0, 20'h0);
    do_lookup("cold_miss", 6'd5, 20'h00ABC, 0, 4'b0000, 0, 4'b0001);
    do_fill(6'd5, 4'b0001);
    do_lookup("fill_hit", 6'd5, 20'h00ABC, 1, 4'b0001, 0, 4'b0000);
    do_lookup("part_miss", 6'd5, 20'h11111, 0, 4'b0000, 0, 4'b0010);

    // Set 3 fully valid; fill order 0,2,1,3 leaves PLRU at 000
    do_fill(6'd3, 4'b0001);
    do_fill(6'd3, 4'b0100);
    do_fill(6'd3, 4'b0010);
    do_fill(6'd3, 4'b1000);
    set_tags(20'h00100, 20'h00101, 20'h00102, 20'h00103);
    do_lookup("plru_miss0", 6'd3, 20'h12345, 0, 4'b0000, 0, 4'b0001);
    do_lookup("hit_w0",     6'd3, 20'h00100, 1, 4'b0001, 0, 4'b0000);
    do_lookup("plru_miss1", 6'd3, 20'h12345, 0, 4'b0000, 0, 4'b0100);
    do_lookup("hit_w2",     6'd3, 20'h00102, 1, 4'b0100, 0, 4'b0000);
    do_lookup("plru_miss2", 6'd3, 20'h12345, 0, 4'b0000, 0, 4'b0010);

    // Backpressure: result held for 3 cycles, no second SRAM read
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_set   = 6'd3;
    req_tag   = 20'h00101;
    #1;
    check("stall.rd_en0", tag_rd_en, 1);
    @(negedge clk);
    check("stall.s1_rd_en", tag_rd_en, 0);
    @(negedge clk);
    check("stall.rsp_valid", rsp_valid, 1);
    check("stall.hit",       hit, 1);
    check("stall.sel",       sel, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall.hold_valid", rsp_valid, 1);
      check("stall.hold_sel",   sel, 4'b0010);
      check("stall.ready_low",  req_ready, 0);
      check("stall.no_rd_en",   tag_rd_en, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("stall.ready_back", req_ready, 1);
    @(negedge clk);
    check("stall.drained", rsp_valid, 0);
    // Handshaked hit on way 1 moves PLRU(3) from 110 to 101
    do_lookup("plru_miss3", 6'd3, 20'h12345, 0, 4'b0000, 0, 4'b1000);

    // Multi-hit on set 7
    do_fill(6'd7, 4'b0010);
    do_fill(6'd7, 4'b0100);
    set_tags(20'h00001, 20'h5A5A5, 20'h5A5A5, 20'h00003);
    do_lookup("multi", 6'd7, 20'h5A5A5, 1, 4'b0010, 1, 4'b0000);

    // Invalidate way 1 leaves only way 2 matching
    @(negedge clk);
    inv_valid = 1'b1;
    inv_set   = 6'd7;
    inv_way   = 4'b0010;
    @(negedge clk);
    inv_valid = 1'b0;
    do_lookup("post_inv", 6'd7, 20'h5A5A5, 1, 4'b0100, 0, 4'b0000);

    // Fill and invalidate of the same way in one cycle: invalidate wins
    @(negedge clk);
    fill_valid = 1'b1;
    fill_set   = 6'd7;
    fill_way   = 4'b0001;
    inv_valid  = 1'b1;
    inv_set    = 6'd7;
    inv_way    = 4'b0001;
    @(negedge clk);
    fill_valid = 1'b0;
    inv_valid  = 1'b0;
    do_lookup("fill_inv", 6'd7, 20'h00001, 0, 4'b0000, 0, 4'b0001);

    // Reset while S1 holds a lookup of filled set 5
    set_tags(20'h00ABC, 20'h0, 20'h0, 20'h0);
    @(negedge clk);
    req_valid = 1'b1;
    req_set   = 6'd5;
    req_tag   = 20'h00ABC;
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst.rsp_valid", rsp_valid, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("mid_rst.hold_rsp", rsp_valid, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst.no_rsp", rsp_valid, 0);
    check("mid_rst.ready",  req_ready, 1);
    do_lookup("post_rst", 6'd5, 20'h00ABC, 0, 4'b0000, 0, 4'b0001);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tag_lookup.md
# tag_lookup

- Upstream stage of the way-select datapath: takes a cache lookup request (set, tag), reads the external tag SRAM and compares all ways.
- Produces the one-hot way-select vector that drives the line-data way mux, plus hit/miss status and a one-hot victim way for refill.
- Owns per-set valid bits and per-set 4-way tree pseudo-LRU state.

## Interface
Parameters:
- WAYS, 4, associativity; fixed at 4 (tree PLRU is 3 bits)
- SETS, 64, number of sets; power of two
- TAG_BITS, 20, tag width

Ports (clock and reset first; reset is asynchronous and active-high):
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_req_valid  in  1  lookup request valid
- o_req_ready  out  1  lookup accepted when valid & ready
- i_req_set  in  $clog2(SETS)  set index
- i_req_tag  in  TAG_BITS  lookup tag
- o_tag_rd_en  out  1  tag SRAM read enable (= i_req_valid & o_req_ready)
- o_tag_rd_set  out  $clog2(SETS)  tag SRAM address (= i_req_set, combinational)
- i_tag_rd_data  in  TAG_BITS x WAYS (unpacked [WAYS-1:0])  tag SRAM data, valid one cycle after o_tag_rd_en
- o_rsp_valid  out  1  result valid
- i_rsp_ready  in  1  downstream accepts result
- o_sel  out  WAYS  one-hot hit way; 0 on miss; feeds the way mux select
- o_hit  out  1  lookup hit
- o_multi_hit  out  1  more than one way matched (error flag)
- o_victim  out  WAYS  one-hot refill way; valid only when o_hit=0
- i_fill_valid  in  1  mark way valid after refill
- i_fill_set  in  $clog2(SETS)  refill set
- i_fill_way  in  WAYS  one-hot refill way
- i_inv_valid  in  1  invalidate request
- i_inv_set  in  $clog2(SETS)  invalidate set
- i_inv_way  in  WAYS  one-hot way to invalidate

## Operation
- Two register stages: S1 (set, tag captured; SRAM read in flight), S2 (registered compare result).
- o_req_ready = !s1_valid & (!s2_valid | i_rsp_ready). S1 therefore always advances to S2 the cycle after acceptance.
- Compare in S1 cycle: match[w] = valid[set][w] & (i_tag_rd_data[w] == tag).
- o_hit = |match. o_sel = lowest-index set bit of match. o_multi_hit = popcount(match) > 1.
- Victim:
  - If any way of the set is invalid: lowest-index invalid way.
  - Otherwise the PLRU choice: b0=0 selects way b1 (0 or 1); b0=1 selects way 2+b2.
- PLRU update on access to way w:
  - w in {0,1}: b0=1, b1=(w==0).
  - w in {2,3}: b0=0, b2=(w==2).
- PLRU is updated at the S2 response handshake (o_rsp_valid & i_rsp_ready) when o_hit, and on i_fill_valid.
- Valid bits:
  - i_fill_valid sets valid[i_fill_set] |= i_fill_way.
  - i_inv_valid clears valid[i_inv_set] &= ~i_inv_way.
  - If fill and invalidate hit the same set/way in the same cycle, invalidate wins.
- PLRU conflict: if fill and a hit handshake update the same set in the same cycle, the fill update wins.
- Non-one-hot i_fill_way or i_inv_way: all set bits are applied. Not a legal use.

## Timing
- Request accepted at cycle N → S1 valid at N+1 (compare) → o_rsp_valid at N+2.
- Best-case throughput is one request per 2 cycles.
- o_rsp_valid holds, with outputs stable, until i_rsp_ready is sampled high.
- Valid-bit visibility: the compare at N+1 uses valid bits as registered at the start of N+1. A fill or invalidate presented during N+1 is not visible to that compare.
- Reset (asynchronous, any time, including mid-operation):
  - s1_valid = s2_valid = 0; in-flight lookups are dropped.
  - All valid bits = 0; all PLRU bits = 000.
  - o_rsp_valid = 0, o_sel = 0, o_hit = 0, o_multi_hit = 0, o_victim = 4'b0001.
  - o_req_ready = 1 once reset is released.

## Structure
- cache_pkg: WAYS, SET_BITS, TAG_BITS localparams; plru_t (3-bit) typedef; onehot_lowest() function.
- Sub-module plru_tree4: combinational victim-from-bits plus next-bits-on-access. Instantiated once per read/update path.
- Valid and PLRU arrays are flops (SETS x 4 and SETS x 3 bits) inside tag_lookup.

## Test plan
- Reset, then lookup set 5 tag 0x00ABC → o_rsp_valid at N+2; o_hit=0, o_sel=0000, o_victim=0001.
- Fill set 5 way 0001, SRAM returns 0x00ABC in way 0, lookup set 5 tag 0x00ABC → o_hit=1, o_sel=0001. After the handshake, PLRU(5)=3'b011 (b0=1, b1=1).
- All 4 ways of set 3 valid, PLRU=000:
  - Lookup miss → o_victim=0001.
  - Then hit way 0 → next miss gives o_victim=0100.
  - Then hit way 2 → next miss gives o_victim=0010.
- Hold i_rsp_ready=0 for 3 cycles with a result pending → o_rsp_valid and o_sel stable; o_req_ready=0; no second o_tag_rd_en issued.
- Ways 1 and 2 both valid with the same tag → o_hit=1, o_sel=0010, o_multi_hit=1.
- Assert i_rst while S1 is valid → o_rsp_valid never rises for that request; the subsequent lookup of a previously filled set misses with o_victim=0001.
